// File: rtl/registers_bank_mp_pkg.sv
// Shared definitions for the multi-port ID-stage register bank and its soft-clear sequencer.
package registers_bank_mp_pkg;

    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned REG_INDEX_WIDTH = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StClear = 2'b01,
        StDone  = 2'b10
    } clear_state_e;

endpackage

// File: rtl/registers_bank_mp_read_port.sv
// One asynchronous read port: applies sweep blanking, the hardwired zero entry and write bypass.
module registers_bank_mp_read_port
    import registers_bank_mp_pkg::*;
#(
    parameter int unsigned AW             = REG_INDEX_WIDTH,
    parameter int unsigned REGISTERS_SIZE = DATA_WIDTH,
    parameter int unsigned N_WRITE_PORTS  = 2,
    parameter bit          BYPASS_EN      = 1'b1,
    parameter bit          ZERO_REG_EN    = 1'b1
) (
    input  logic [AW-1:0]                           i_read_register,
    input  logic [REGISTERS_SIZE-1:0]               i_entry,
    input  logic [N_WRITE_PORTS-1:0]                i_write_enable,
    input  logic [N_WRITE_PORTS*AW-1:0]             i_write_register,
    input  logic [N_WRITE_PORTS*REGISTERS_SIZE-1:0] i_write_data,
    input  logic                                    i_busy,
    output logic [REGISTERS_SIZE-1:0]               o_read_data
);

    always_comb begin
        o_read_data = i_entry;
        // Ascending scan so the highest-numbered matching port wins.
        if (BYPASS_EN) begin
            for (int p = 0; p < int'(N_WRITE_PORTS); p++) begin
                if (i_write_enable[p] && (i_write_register[p*AW +: AW] == i_read_register)) begin
                    o_read_data = i_write_data[p*REGISTERS_SIZE +: REGISTERS_SIZE];
                end
            end
        end
        if (ZERO_REG_EN && (i_read_register == '0)) begin
            o_read_data = '0;
        end
        if (i_busy) begin
            o_read_data = '0;
        end
    end

endmodule

// File: rtl/registers_bank_mp.sv
// Multi-port register bank with write-first bypass, optional zero entry and a one-entry-per-cycle
// soft-clear sweep.
module registers_bank_mp
    import registers_bank_mp_pkg::*;
#(
    parameter int unsigned REGISTERS_BANK_SIZE = 32,
    parameter int unsigned REGISTERS_SIZE      = DATA_WIDTH,
    parameter int unsigned N_READ_PORTS        = 2,
    parameter int unsigned N_WRITE_PORTS       = 2,
    parameter bit          BYPASS_EN           = 1'b1,
    parameter bit          ZERO_REG_EN         = 1'b1,
    localparam int unsigned AW                 = $clog2(REGISTERS_BANK_SIZE)
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic [N_WRITE_PORTS-1:0]                i_write_enable,
    input  logic [N_WRITE_PORTS*AW-1:0]             i_write_register,
    input  logic [N_WRITE_PORTS*REGISTERS_SIZE-1:0] i_write_data,
    input  logic [N_READ_PORTS*AW-1:0]              i_read_register,
    output logic [N_READ_PORTS*REGISTERS_SIZE-1:0]  o_read_data,
    input  logic                                    i_clear,
    output logic                                    o_clear_busy,
    output logic                                    o_clear_done
);

    logic [REGISTERS_SIZE-1:0] r_bank [REGISTERS_BANK_SIZE];
    clear_state_e              r_state, w_state_next;
    logic [AW-1:0]             r_count, w_count_next;
    logic                      w_busy;

    assign w_busy       = (r_state == StClear);
    assign o_clear_busy = w_busy;
    assign o_clear_done = (r_state == StDone);

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        unique case (r_state)
            StIdle: begin
                if (i_clear) begin
                    w_state_next = StClear;
                    w_count_next = '0;
                end
            end
            StClear: begin
                w_count_next = r_count + 1'b1;
                if (r_count == AW'(REGISTERS_BANK_SIZE - 1)) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Later loop iterations override earlier ones, so the highest-numbered port wins a collision.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(REGISTERS_BANK_SIZE); i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_busy) begin
            r_bank[r_count] <= '0;
        end else begin
            for (int p = 0; p < int'(N_WRITE_PORTS); p++) begin
                if (i_write_enable[p] &&
                    !(ZERO_REG_EN && (i_write_register[p*AW +: AW] == '0))) begin
                    r_bank[i_write_register[p*AW +: AW]] <=
                        i_write_data[p*REGISTERS_SIZE +: REGISTERS_SIZE];
                end
            end
        end
    end

    for (genvar r = 0; r < int'(N_READ_PORTS); r++) begin : g_read
        registers_bank_mp_read_port #(
            .AW             (AW),
            .REGISTERS_SIZE (REGISTERS_SIZE),
            .N_WRITE_PORTS  (N_WRITE_PORTS),
            .BYPASS_EN      (BYPASS_EN),
            .ZERO_REG_EN    (ZERO_REG_EN)
        ) u_read_port (
            .i_read_register  (i_read_register[r*AW +: AW]),
            .i_entry          (r_bank[i_read_register[r*AW +: AW]]),
            .i_write_enable   (i_write_enable),
            .i_write_register (i_write_register),
            .i_write_data     (i_write_data),
            .i_busy           (w_busy),
            .o_read_data      (o_read_data[r*REGISTERS_SIZE +: REGISTERS_SIZE])
        );
    end

endmodule

// File: doc/registers_bank_mp.md
Name: registers_bank_mp

Overview:
Parametrised successor of the ID-stage register bank. It provides N read ports and M write ports, optional write-to-read bypass (write-first forwarding for WB→ID hazards), and an optional hardwired zero register. It also adds a sequential soft-clear sequencer that zeroes the bank one entry per cycle on request. It sits in the ID stage, fed by WB write-back; the second write port serves a future dual-issue or debug-load path.

Parameters:
REGISTERS_BANK_SIZE, 32, number of entries (≥2, power of two)
REGISTERS_SIZE, `DATA_WIDTH (32), width of each entry
N_READ_PORTS, 2, number of asynchronous read ports
N_WRITE_PORTS, 2, number of synchronous write ports
BYPASS_EN, 1, 1 = same-cycle write data forwarded to matching reads
ZERO_REG_EN, 1, 1 = entry 0 reads 0 and ignores writes
(AW = $clog2(REGISTERS_BANK_SIZE), derived localparam)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_write_enable  in  N_WRITE_PORTS  per-port write enable
i_write_register  in  N_WRITE_PORTS*AW  packed write indices, port p at [p*AW +: AW]
i_write_data  in  N_WRITE_PORTS*REGISTERS_SIZE  packed write data
i_read_register  in  N_READ_PORTS*AW  packed read indices
o_read_data  out  N_READ_PORTS*REGISTERS_SIZE  packed read data, combinational
i_clear  in  1  soft-clear request, single-cycle pulse or level
o_clear_busy  out  1  high while the sequencer is sweeping
o_clear_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_reset), sampled on posedge.
- Reset: all entries = 0 in a single cycle; FSM → IDLE; clear counter = 0; o_clear_busy = 0; o_clear_done = 0. Reset has priority over writes and clear. Reset during a sweep aborts it with no done pulse.
- FSM has three states:
  - IDLE: i_clear=1 → CLEAR, counter = 0.
  - CLEAR: each cycle writes 0 to entry[counter] and increments counter. When counter = REGISTERS_BANK_SIZE-1 the FSM writes that entry and → DONE.
  - DONE: o_clear_done = 1 for exactly this cycle, then → IDLE.
  - Sweep latency: REGISTERS_BANK_SIZE cycles of busy plus 1 done cycle.
- o_clear_busy = (state == CLEAR), registered from the state.
- i_clear is ignored in CLEAR and DONE. It is not queued.
- Writes (IDLE or DONE only): on posedge, each port p with enable=1 writes data to its index.
  - Two ports to the same index: the highest-numbered port wins.
  - ZERO_REG_EN=1: writes to index 0 are discarded.
  - In CLEAR, all functional writes are dropped, with no error indication.
- Reads are asynchronous. Read port r returns:
  - 0 if state == CLEAR.
  - Else 0 if ZERO_REG_EN and index = 0.
  - Else, if BYPASS_EN and any enabled write port targets the same index this cycle, that port's write data (highest-numbered matching port).
  - Else the stored entry.
- BYPASS_EN=0: reads return the stored value; a write becomes visible the cycle after the edge.
- No output is X after reset; o_read_data is 0 for all ports immediately after reset.

Decomposition:
- Shared package mips_pkg.vh:
  - `DATA_WIDTH (existing)
  - `REG_INDEX_WIDTH (5)
  - `REG_CLEAR_IDLE / `REG_CLEAR_SWEEP / `REG_CLEAR_DONE state encodings (2-bit)
- Sub-module registers_read_port: one per read port via generate.
  - Inputs: read index, stored entry value, packed write enables/indices/data, busy flag.
  - Implements the zero, bypass and priority mux.
  - Keeps the top level to storage, the write loop and the FSM.

Test Plan:
- Reset, then read all 32 indices on both ports → every o_read_data = 0; o_clear_busy = 0.
- Port0 writes reg5 = 0xDEADBEEF; read port1 at reg5 in the same cycle → 0xDEADBEEF (bypass). With BYPASS_EN=0 → 0 in that cycle, 0xDEADBEEF in the next.
- Port0 writes reg7 = 0x11111111 and port1 writes reg7 = 0x22222222 in the same cycle → reg7 reads 0x22222222. Writing reg0 = 0xFFFFFFFF → reg0 reads 0, including the bypass path.
- Fill regs 1..31 with their index. Pulse i_clear → o_clear_busy high for exactly 32 cycles and o_clear_done pulses once on cycle 33. A write to reg3 during the sweep is dropped. Afterwards every reg reads 0.
- Start a sweep, assert i_reset at sweep cycle 10 → busy drops the next cycle, no done pulse, all regs 0. A new i_clear is accepted normally afterwards.
- Pulse i_clear again at sweep cycle 4 → ignored: total busy is still 32 cycles and only one done pulse occurs.
